// File: rtl/bcd_pkg.sv
// Shared keypad types: BCD digit, largest legal digit and the key-debounce FSM states.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RELEASE
    } key_state_t;

endpackage

// File: rtl/bcd_digit_entry_if.sv
// Encoder-to-entry bus: key digit, valid level and commands in; live buffer, flags and committed value out.
interface bcd_digit_entry_if #(
    parameter int NDIG = 4
);
    import bcd_pkg::*;

    localparam int CNT_W = $clog2(NDIG + 1);

    bcd_t              bcd_in;
    logic              valid_in;
    logic              clear;
    logic              enter;
    logic [4*NDIG-1:0] digits_out;
    logic [CNT_W-1:0]  digit_count;
    logic              full;
    logic              overflow;
    logic [4*NDIG-1:0] value_out;
    logic              value_strobe;

    modport master (
        output bcd_in, valid_in, clear, enter,
        input  digits_out, digit_count, full, overflow, value_out, value_strobe
    );

    modport slave (
        input  bcd_in, valid_in, clear, enter,
        output digits_out, digit_count, full, overflow, value_out, value_strobe
    );

endinterface

// File: rtl/key_release_filter.sv
// Turns a bouncy valid level into one accept pulse per press, re-arming only after
// RELEASE_CYCLES consecutive low cycles.
module key_release_filter
    import bcd_pkg::*;
#(
    parameter int RELEASE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    output logic accept_pulse
);

    localparam int RC_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RELEASE_CYCLES);

    key_state_t      state;
    logic [RC_W-1:0] rel_cnt;

    // rel_cnt counts low cycles already seen; the first one is sampled in HELD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rel_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) state <= HELD;
                end
                HELD: begin
                    if (!valid_in) begin
                        state   <= RELEASE;
                        rel_cnt <= RC_W'(1);
                    end
                end
                RELEASE: begin
                    if (rel_cnt == RC_MAX) begin
                        state   <= IDLE;
                        rel_cnt <= '0;
                    end else if (valid_in) begin
                        state   <= HELD;
                        rel_cnt <= '0;
                    end else begin
                        rel_cnt <= rel_cnt + RC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rel_cnt <= '0;
                end
            endcase
        end
    end

    // Decoded from state so the digit lands on the same edge that leaves IDLE.
    assign accept_pulse = (state == IDLE) && valid_in;

endmodule

// File: rtl/bcd_digit_entry.sv
// Multi-digit BCD entry buffer: shifts in accepted key digits, tracks count/overflow and
// commits the buffer to value_out on enter.
module bcd_digit_entry
    import bcd_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_digit_entry_if.slave bus
);

    localparam int CNT_W = $clog2(NDIG + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDIG);

    logic              accept_pulse;
    logic [4*NDIG-1:0] digits_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic [4*NDIG-1:0] value_q;
    logic              strobe_q;
    logic              full_w;
    logic              digit_ok;

    key_release_filter #(
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (bus.valid_in),
        .accept_pulse(accept_pulse)
    );

    assign full_w   = (count_q == CNT_MAX);
    assign digit_ok = accept_pulse && (bus.bcd_in <= BCD_MAX);

    // clear beats enter beats capture; a press lost to clear/enter is still consumed by the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            value_q    <= '0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (bus.clear) begin
                digits_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (bus.enter) begin
                value_q    <= digits_q;
                strobe_q   <= 1'b1;
                digits_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (digit_ok) begin
                if (full_w) begin
                    overflow_q <= 1'b1;
                end else begin
                    digits_q <= {digits_q[4*NDIG-5:0], bus.bcd_in};
                    count_q  <= count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.digits_out   = digits_q;
    assign bus.digit_count  = count_q;
    assign bus.full         = full_w;
    assign bus.overflow     = overflow_q;
    assign bus.value_out    = value_q;
    assign bus.value_strobe = strobe_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry (NDIG=4, RELEASE_CYCLES=16); inputs change and outputs
// are sampled on the falling clock edge.
module tb_bcd_digit_entry;
    import bcd_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bcd_digit_entry_if #(.NDIG(4)) bus ();

    bcd_digit_entry #(
        .NDIG          (4),
        .RELEASE_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic [3:0] d, input int hi, input int lo);
        bus.bcd_in   = d;
        bus.valid_in = 1'b1;
        repeat (hi) @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.bcd_in   = 4'd0;
        bus.valid_in = 1'b0;
        bus.clear    = 1'b0;
        bus.enter    = 1'b0;
        #3;
        checks++;
        if (bus.digits_out !== 16'h0000 || bus.digit_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_buf digits=%h count=%0d required 0000/0", bus.digits_out, bus.digit_count);
        end
        checks++;
        if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.value_out !== 16'h0000 || bus.value_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags full=%b ovf=%b value=%h strobe=%b required 0/0/0000/0",
                     bus.full, bus.overflow, bus.value_out, bus.value_strobe);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_digits();
        bus.bcd_in   = 4'd1;
        bus.valid_in = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.digits_out !== 16'h0001) begin
            failures++;
            $display("FAIL capture_latency digits=%h required 0001", bus.digits_out);
        end
        repeat (4) @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (20) @(negedge clk);
        press(4'd2, 5, 20);
        press(4'd3, 5, 20);
        checks++;
        if (bus.digits_out !== 16'h0123 || bus.digit_count !== 3'd3 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL digits_123 digits=%h count=%0d full=%b required 0123/3/0",
                     bus.digits_out, bus.digit_count, bus.full);
        end
    endtask

    task automatic test_bounce();
        pulse_clear();
        bus.bcd_in   = 4'd7;
        bus.valid_in = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1'b0;
            repeat (3) @(negedge clk);
            bus.valid_in = 1'b1;
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.digits_out !== 16'h0007 || bus.digit_count !== 3'd1) begin
            failures++;
            $display("FAIL bounce digits=%h count=%0d required 0007/1", bus.digits_out, bus.digit_count);
        end
    endtask

    task automatic test_enter();
        pulse_clear();
        press(4'd4, 5, 20);
        press(4'd2, 5, 20);
        checks++;
        if (bus.value_strobe !== 1'b0) begin
            failures++;
            $display("FAIL strobe_idle strobe=%b required 0", bus.value_strobe);
        end
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        checks++;
        if (bus.value_out !== 16'h0042 || bus.value_strobe !== 1'b1) begin
            failures++;
            $display("FAIL enter_commit value=%h strobe=%b required 0042/1", bus.value_out, bus.value_strobe);
        end
        checks++;
        if (bus.digits_out !== 16'h0000 || bus.digit_count !== 3'd0) begin
            failures++;
            $display("FAIL enter_clears digits=%h count=%0d required 0000/0", bus.digits_out, bus.digit_count);
        end
        @(negedge clk);
        checks++;
        if (bus.value_strobe !== 1'b0 || bus.value_out !== 16'h0042) begin
            failures++;
            $display("FAIL strobe_width strobe=%b value=%h required 0/0042", bus.value_strobe, bus.value_out);
        end
    endtask

    task automatic test_overflow();
        for (int d = 1; d <= 4; d++) press(4'(d), 5, 20);
        checks++;
        if (bus.digits_out !== 16'h1234 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill digits=%h full=%b ovf=%b required 1234/1/0", bus.digits_out, bus.full, bus.overflow);
        end
        press(4'd5, 5, 20);
        checks++;
        if (bus.digits_out !== 16'h1234 || bus.digit_count !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow digits=%h count=%0d full=%b ovf=%b required 1234/4/1/1",
                     bus.digits_out, bus.digit_count, bus.full, bus.overflow);
        end
        pulse_clear();
        checks++;
        if (bus.digits_out !== 16'h0000 || bus.digit_count !== 3'd0 || bus.overflow !== 1'b0 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL clear digits=%h count=%0d ovf=%b full=%b required 0000/0/0/0",
                     bus.digits_out, bus.digit_count, bus.overflow, bus.full);
        end
        checks++;
        if (bus.value_out !== 16'h0042 || bus.value_strobe !== 1'b0) begin
            failures++;
            $display("FAIL clear_keeps_value value=%h strobe=%b required 0042/0", bus.value_out, bus.value_strobe);
        end
    endtask

    task automatic test_invalid_bcd();
        press(4'd5, 5, 20);
        press(4'hB, 5, 20);
        checks++;
        if (bus.digits_out !== 16'h0005 || bus.digit_count !== 3'd1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL invalid_bcd digits=%h count=%0d ovf=%b required 0005/1/0",
                     bus.digits_out, bus.digit_count, bus.overflow);
        end
        press(4'd6, 5, 20);
        checks++;
        if (bus.digits_out !== 16'h0056 || bus.digit_count !== 3'd2) begin
            failures++;
            $display("FAIL after_invalid digits=%h count=%0d required 0056/2", bus.digits_out, bus.digit_count);
        end
    endtask

    task automatic test_clear_collision();
        bus.bcd_in   = 4'd8;
        bus.valid_in = 1'b1;
        bus.clear    = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++;
        if (bus.digits_out !== 16'h0000 || bus.digit_count !== 3'd0) begin
            failures++;
            $display("FAIL clear_wins digits=%h count=%0d required 0000/0", bus.digits_out, bus.digit_count);
        end
        repeat (3) @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.digits_out !== 16'h0000 || bus.digit_count !== 3'd0) begin
            failures++;
            $display("FAIL press_consumed digits=%h count=%0d required 0000/0", bus.digits_out, bus.digit_count);
        end
        press(4'd9, 5, 20);
        checks++;
        if (bus.digits_out !== 16'h0009 || bus.digit_count !== 3'd1) begin
            failures++;
            $display("FAIL after_collision digits=%h count=%0d required 0009/1", bus.digits_out, bus.digit_count);
        end
    endtask

    task automatic test_reset_mid_press();
        bus.bcd_in   = 4'd3;
        bus.valid_in = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.digits_out !== 16'h0093 || bus.digit_count !== 3'd2) begin
            failures++;
            $display("FAIL pre_reset digits=%h count=%0d required 0093/2", bus.digits_out, bus.digit_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.digits_out !== 16'h0000 || bus.digit_count !== 3'd0 || bus.value_out !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset digits=%h count=%0d value=%h required 0000/0/0000",
                     bus.digits_out, bus.digit_count, bus.value_out);
        end
        checks++;
        if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.value_strobe !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_flags full=%b ovf=%b strobe=%b required 0/0/0",
                     bus.full, bus.overflow, bus.value_strobe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.digits_out !== 16'h0003 || bus.digit_count !== 3'd1) begin
            failures++;
            $display("FAIL recapture digits=%h count=%0d required 0003/1", bus.digits_out, bus.digit_count);
        end
        bus.valid_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_digits();
        test_bounce();
        test_enter();
        test_overflow();
        test_invalid_bcd();
        test_clear_collision();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
